capture_buffer: RTL and testbench

//   Sample memory for the tiny logic analyzer; sits directly downstream of the trigger stage.

---
 rtl/capture_buffer.sv | 199 +++++++++++++++++++
 tb/tb_capture_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// Capture buffer for the logic analyzer: circular pre/post-trigger sample store with valid/ready readout.
// Optional build macro SAMPLE_DIV_EN adds an 8-bit sample_div port that slows the write strobe.
module capture_buffer #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             trig,
  input  logic [WIDTH-1:0] in_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             done
`ifdef SAMPLE_DIV_EN
  ,
  input  logic [7:0]       sample_div
`endif
);

  localparam int CW = $clog2(DEPTH);
  localparam int POST_LEN = DEPTH - PRE_TRIG;

  localparam logic [CW-1:0] PRE_FULL  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_END  = CW'(POST_LEN - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    POST,
    READ
  } state_t;

  state_t        state;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] pre_cnt;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] beat_cnt;
  logic          s;
  logic          capturing;
  logic          wr_en;

  logic [WIDTH-1:0] mem [DEPTH];

  assign capturing = (state == FILL) || (state == POST);
  assign wr_en     = arm && s && capturing;

  // ---------------------------------------------------------------------------
  // Sample strobe
  // ---------------------------------------------------------------------------
`ifdef SAMPLE_DIV_EN
  logic [7:0] div_cnt;
  logic [7:0] div_max;

  // The divisor is latched at arm time so a mid-capture change cannot skew the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      div_max <= '0;
    end else if (!arm) begin
      div_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      div_max <= sample_div;
    end else if (capturing) begin
      div_cnt <= (div_cnt == div_max) ? 8'd0 : div_cnt + 8'd1;
    end
  end

  assign s = (div_cnt == 8'd0);
`else
  assign s = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------------
  // NOTE: the sample array has no reset; its contents are only ever read after a
  // full window has been written, and a reset would turn it into flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Gated so every output reads 0 out of reset and between captures.
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Control FSM with registered status outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state and status registers use non-blocking assignments so every
  // branch below sees the pre-edge values of the counters it compares against.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (!arm) begin
      // Abort outranks trigger and handshake; the partial capture is dropped.
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FILL;
          wr_ptr  <= '0;
          pre_cnt <= '0;
          busy    <= 1'b1;
        end

        FILL: begin
          if (s) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (trig && (pre_cnt == PRE_FULL)) begin
              post_cnt <= CW'(1);
              if (POST_LEN == 1) begin
                // The trigger sample alone completes the window.
                state    <= READ;
                rd_ptr   <= wr_ptr + 1'b1;
                beat_cnt <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
                rd_valid <= 1'b1;
                rd_last  <= 1'b0;
              end else begin
                state <= POST;
              end
            end else if (pre_cnt != PRE_FULL) begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end

        POST: begin
          if (s) begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == POST_END) begin
              // Oldest sample of the window sits just past the final write.
              state    <= READ;
              rd_ptr   <= wr_ptr + 1'b1;
              beat_cnt <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              rd_valid <= 1'b1;
              rd_last  <= 1'b0;
            end
          end
        end

        READ: begin
          if (rd_ready) begin
            rd_ptr   <= rd_ptr + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            rd_last  <= (beat_cnt == PRE_LAST);
            if (beat_cnt == LAST_BEAT) begin
              state    <= IDLE;
              beat_cnt <= '0;
              post_cnt <= '0;
              done     <= 1'b0;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed self-checking bench for capture_buffer (DEPTH=16, PRE_TRIG=4, WIDTH=4).
// Define SAMPLE_DIV_EN for both bench and RTL to also exercise the sample divider.
module tb_capture_buffer;

  logic       clk;
  logic       rst;
  logic       arm;
  logic       trig;
  logic [3:0] in_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       done;
`ifdef SAMPLE_DIV_EN
  logic [7:0] sample_div;
`endif

  int n_checks = 0;
  int n_errors = 0;

  capture_buffer #(
    .WIDTH   (4),
    .DEPTH   (16),
    .PRE_TRIG(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .arm     (arm),
    .trig    (trig),
    .in_data (in_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .rd_last (rd_last),
    .busy    (busy),
    .done    (done)
`ifdef SAMPLE_DIV_EN
    ,
    .sample_div(sample_div)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_valid"}, rd_valid, 1'b0);
  endtask

  // Arm, stream in_data = sample index, raise trig on samples t1/t2, and expect
  // done right after sample exp_k is written.
  task automatic capture(input int t1, input int t2, input int exp_k);
    int  k;
    bit  seen;
    k    = 0;
    seen = 1'b0;
    arm      = 1'b1;
    trig     = 1'b0;
    rd_ready = 1'b0;
    in_data  = '0;
    tick();
    check("fill_busy", busy, 1'b1);
    check("fill_done", done, 1'b0);
    while (!seen && k < 64) begin
      in_data = k[3:0];
      trig    = (k == t1) || (k == t2);
      tick();
      if (done) seen = 1'b1;
      else k++;
    end
    trig = 1'b0;
    check("done_sample", k, exp_k);
    check("read_busy", busy, 1'b0);
    check("read_valid", rd_valid, 1'b1);
  endtask

  // Drain the window expecting (base + beat) mod 16. mode 1 drives ready 1,0,0,...
  // abort_beat >= 0 drops arm (with ready high) when that beat is presented.
  task automatic read_window(input int base, input int mode, input int abort_beat);
    int beat;
    int c;
    beat = 0;
    c    = 0;
    while (beat < 16 && c < 200) begin
      rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      if (beat == abort_beat) begin
        arm      = 1'b0;
        rd_ready = 1'b1;
        tick();
        check_idle("abort_read");
        check("abort_last", rd_last, 1'b0);
        rd_ready = 1'b0;
        return;
      end
      check("rd_valid", rd_valid, 1'b1);
      check("rd_data", rd_data, (base + beat) % 16);
      check("rd_last", rd_last, beat == 15);
      tick();
      if (rd_ready) beat++;
      c++;
    end
    rd_ready = 1'b0;
    check("beat_count", beat, 16);
    check_idle("after_read");
    arm = 1'b0;
    tick();
    check_idle("parked");
  endtask

  initial begin
    rst      = 1'b1;
    arm      = 1'b0;
    trig     = 1'b0;
    in_data  = '0;
    rd_ready = 1'b0;
`ifdef SAMPLE_DIV_EN
    sample_div = 8'd0;
`endif
    tick();
    check_idle("reset");
    check("reset_last", rd_last, 1'b0);
    check("reset_data", rd_data, 4'h0);
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Basic: trigger on sample 9, window 5..20
    capture(9, -1, 20);
    read_window(5, 0, -1);

    // Early trigger on sample 2 ignored, takes at 4
    capture(2, 4, 15);
    read_window(0, 0, -1);

    // Backpressure
    capture(9, -1, 20);
    read_window(5, 1, -1);

    // Abort in POST
    arm = 1'b1;
    tick();
    for (int k = 0; k <= 12; k++) begin
      in_data = k[3:0];
      trig    = (k == 9);
      tick();
    end
    trig = 1'b0;
    check("post_busy", busy, 1'b1);
    arm = 1'b0;
    tick();
    check_idle("abort_post");
    capture(9, -1, 20);
    read_window(5, 0, -1);

    // Abort mid-READ at beat 7, then a clean capture
    capture(9, -1, 20);
    read_window(5, 0, 7);
    capture(6, -1, 17);
    read_window(2, 0, -1);

    // Async reset during FILL
    arm = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      in_data = k[3:0];
      tick();
    end
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_last", rd_last, 1'b0);
    check("async_rst_data", rd_data, 4'h0);
    arm = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    capture(9, -1, 20);
    read_window(5, 0, -1);

`ifdef SAMPLE_DIV_EN
    // Divide by 3: trigger on the 6th strobed sample (index 5)
    begin
      int  c;
      bit  seen;
      c          = 0;
      seen       = 1'b0;
      sample_div = 8'd2;
      arm        = 1'b1;
      tick();
      while (!seen && c < 200) begin
        in_data = 4'((c / 3) % 16);
        trig    = ((c / 3) == 5);
        tick();
        if (done) seen = 1'b1;
        else c++;
      end
      trig = 1'b0;
      check("div_done_cycle", c - 15, 33);
      read_window(1, 0, -1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
